// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH).
// One full-subtractor cell processes one bit per clock, LSB first, with the
// borrow held in a flop between bits. Control is a start/done handshake.
// An operation takes WIDTH SHIFT cycles plus one DONE cycle, and the unit
// accepts a new start at most once every WIDTH+2 cycles.
//
// Parameters:
//   WIDTH       operand/result width in bits (2..32)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request, sampled only in IDLE
//   a, b        minuend / subtrahend, captured when start is accepted
//   busy        high while the bit-serial loop runs (SHIFT)
//   done        one-cycle pulse when diff/borrow_out are valid
//   diff        a - b modulo 2^WIDTH, held until the next result
//   borrow_out  final borrow (unsigned a < unsigned b)
//   ovf         signed overflow flag (only when SERIAL_SUB_OVF_EN is defined)
//
// Build option:
//   SERIAL_SUB_OVF_EN  adds the ovf output and the operand MSB capture flops.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  logic w_d;
  logic w_borrow_nxt;
  logic w_last;

  // Full-subtractor cell on the current LSBs.
  assign w_d          = r_a_sr[0] ^ r_b_sr[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_borrow);
  assign w_last       = (r_cnt == LAST_CNT);

  // NOTE: every register in this block uses non-blocking assignment so that
  // all right-hand sides see pre-edge values; the shifts and the borrow
  // update depend on that ordering-free behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are cleared on reset along with the control
      // state, so no stale operand bits survive an abandoned operation.
      r_state      <= ST_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_r_sr       <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb      <= 1'b0;
      r_b_msb      <= 1'b0;
      r_ovf        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_r_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
            r_state  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_r_sr   <= {w_d, r_r_sr[WIDTH-1:1]};
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // The bit computed on this edge is the result MSB, so the
            // published value includes it directly.
            r_diff       <= {w_d, r_r_sr[WIDTH-1:1]};
            r_borrow_out <= w_borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf        <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
            r_state      <= ST_DONE;
          end
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_SHIFT);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. A WIDTH=8 instance is tracked by
// a cycle-level reference model (cycles since accept, expected result computed
// with plain integer arithmetic) and compared on every falling edge. Directed
// operations pin the model with literal expectations; a WIDTH=4 instance is
// swept over all operand pairs. Honours SERIAL_SUB_OVF_EN.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0;
  logic [W4-1:0] b4 = '0;
  logic          busy4, done4, bo4;
  logic [W4-1:0] diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic          ovf4;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (bo4)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: m_t counts edges since the accepting edge (-1 = idle).
  // busy for m_t in 0..W-1, done at m_t == W, back to idle one edge later.
  // ---------------------------------------------------------------------------
  int           m_t = -1;
  logic [W-1:0] m_diff = '0, m_pdiff = '0;
  logic         m_bo = 1'b0, m_pbo = 1'b0;
  logic         m_ovf = 1'b0, m_povf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    = -1;
      m_diff = '0;
      m_bo   = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_t < 0) begin
      if (start) begin
        int sa, sb, sd;
        m_t     = 0;
        m_pdiff = W'(int'(a) - int'(b));
        m_pbo   = (a < b);
        sa      = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb      = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd      = sa - sb;
        m_povf  = (sd >= (1 << (W - 1))) || (sd < -(1 << (W - 1)));
      end
    end else begin
      m_t++;
      if (m_t == W) begin
        m_diff = m_pdiff;
        m_bo   = m_pbo;
        m_ovf  = m_povf;
      end else if (m_t == W + 1) begin
        m_t = -1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (m_t >= 0 && m_t < W));
    check("done", done, (m_t == W));
    check("diff", diff, m_diff);
    check("borrow_out", borrow_out, m_bo);
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", ovf, m_ovf);
`endif
    if (busy && done) check("busy_and_done", 1'b1, 1'b0);
  end

  // Wait for idle, issue one start, return the first negedge after accept.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    int guard = 0;
    @(negedge clk);
    while (m_t >= 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after launch; lat counts edges after accept until done.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] exp_d, input logic exp_b, input string tag);
    int lat, bcnt;
    launch(ta, tb_v);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, lat, W);
    check({tag, "_diff"}, diff, exp_d);
    check({tag, "_borrow"}, borrow_out, exp_b);
  endtask

  initial begin
    int lat, bcnt, npulse;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 1'b0);
    #2 rst_n = 1'b1;

    // 5 - 3: latency and busy length pinned
    launch(8'd5, 8'd3);
    wait_done(lat, bcnt);
    check("op53_lat", lat, 8);
    check("op53_busy_cycles", bcnt, 8);
    check("op53_diff", diff, 2);
    check("op53_borrow", borrow_out, 1'b0);

    do_op(8'd3,   8'd5,   8'd254, 1'b1, "op35");
    do_op(8'd0,   8'd0,   8'd0,   1'b0, "op00");
    do_op(8'd255, 8'd255, 8'd0,   1'b0, "opff");

    // 0 - 1 with a start pulse during SHIFT that must be ignored
    launch(8'd0, 8'd1);
    @(negedge clk);
    a = 8'd9; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("op01_diff", diff, 255);
    check("op01_borrow", borrow_out, 1'b1);
    @(negedge clk);
    check("op01_single_pulse", done, 1'b0);
    a = 8'd9; b = 8'd1; start = 1'b1;   // sampled two edges after done
    @(negedge clk);
    start = 1'b0;
    check("op91_accepted", busy, 1'b1);
    wait_done(lat, bcnt);
    check("op91_diff", diff, 8);

    // Reset in the middle of an operation
    launch(8'd100, 8'd20);
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_diff", diff, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    npulse = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("mid_no_done", npulse, 0);
    do_op(8'd100, 8'd20, 8'd80, 1'b0, "op100_20");

`ifdef SERIAL_SUB_OVF_EN
    do_op(8'h80, 8'h01, 8'h7f, 1'b0, "ovf1");
    check("ovf1_flag", ovf, 1'b1);
    do_op(8'h7f, 8'hff, 8'h80, 1'b1, "ovf2");
    check("ovf2_flag", ovf, 1'b1);
    do_op(8'h10, 8'h01, 8'h0f, 1'b0, "ovf3");
    check("ovf3_flag", ovf, 1'b0);
`endif

    // Randomized traffic: free-running start/a/b, occasional async reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      if (i % 700 == 350) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int g;
        @(negedge clk);
        a4 = W4'(ia);
        b4 = W4'(ib);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        g = 0;
        while (!done4 && g < 20) begin
          @(negedge clk);
          g++;
        end
        check("w4_lat", g, W4);
        check("w4_diff", diff4, (ia - ib) & 15);
        check("w4_borrow", bo4, (ia < ib));
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, two's-complement subtractor. It is the inverse-direction companion to the team's combinational full adder and computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It sits beside the adder in the arithmetic lab datapath as a low-area sequential unit. Control is a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start.
- b, input, WIDTH, subtrahend; captured on the accepted start.
- busy, output, 1, high while in the SHIFT state.
- done, output, 1, one-cycle pulse when the result is valid.
- diff, output, WIDTH, result a - b modulo 2^WIDTH; held until the next result.
- borrow_out, output, 1, final borrow; 1 when unsigned a < unsigned b.

Behaviour:
- Reset: clk is a single clock; rst_n is asynchronous and active-low. While rst_n = 0:
  - state = IDLE;
  - busy = 0, done = 0, diff = 0, borrow_out = 0;
  - internal shift registers, borrow flop and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when start = 1 at a clock edge. At that edge: load a_sr <= a, b_sr <= b, borrow <= 0, cnt <= 0.
  - SHIFT, each edge:
    - d = a_sr[0] ^ b_sr[0] ^ borrow.
    - borrow <= (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow).
    - a_sr and b_sr shift right by 1.
    - r_sr shifts right with d inserted at the MSB.
    - cnt <= cnt + 1.
  - SHIFT -> DONE on the edge that processes bit WIDTH-1 (cnt == WIDTH-1). At that edge:
    - diff <= final r_sr value, including that bit;
    - borrow_out <= final borrow.
  - DONE -> IDLE unconditionally on the next edge.
- Latency: start accepted at edge k; done = 1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
- Next accept: the earliest next start is accepted at edge k+WIDTH+2, which gives a throughput of one operation per WIDTH+2 cycles.
- busy = 1 exactly while state == SHIFT. busy and done are never high together.
- start while in SHIFT or DONE is ignored. a and b may change freely after the accepting edge; they are not re-sampled.
- diff and borrow_out change only on the SHIFT -> DONE edge or on reset. They are stable at all other times.
- Counter width is clog2(WIDTH) bits. There is no wrap inside an operation.
- Equal operands: diff = 0, borrow_out = 0.
- Reset mid-operation: the operation is abandoned immediately (asynchronous). No done pulse is produced, and outputs return to their reset values.
- start held high continuously: a new operation begins on every visit to IDLE.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), which is the signed two's-complement overflow flag.
  - Computed as (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the captured operand MSBs.
  - Registered on the same edge as diff; reset value 0; held like diff.
- Not defined: port ovf is absent and no MSB capture logic is built.

Test Plan:
- WIDTH=8, start with a=5, b=3 -> done high at cycle 8 after accept; diff=2, borrow_out=0; busy high for exactly 8 cycles.
- a=3, b=5 -> diff=254, borrow_out=1. Also a=0, b=0 -> diff=0, borrow_out=0. Also a=255, b=255 -> diff=0, borrow_out=0.
- a=0, b=1 -> diff=255, borrow_out=1. Pulse start again during SHIFT with a=9, b=1 -> ignored: single done pulse, diff=255. A start two cycles after done is accepted and yields 8.
- Start a=100, b=20; drive rst_n=0 after 4 SHIFT cycles -> busy=0, done=0, diff=0 immediately; no done pulse after release. Then start a=100, b=20 -> diff=80.
- Exhaustive sweep with WIDTH=4, all 256 a/b pairs -> diff == (a-b) mod 16 and borrow_out == (a<b) on every done pulse.
- SERIAL_SUB_OVF_EN defined, WIDTH=8:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1;
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1;
  - a=0x10, b=0x01 -> ovf=0.
